// File: rtl/jk_reg_bank_pkg.sv
// Shared write-mode encodings and the per-bit JK next-state function for jk_reg_bank.
// jk_next works on MAX_WIDTH-bit vectors; callers zero-extend and truncate (WIDTH <= 64).
package jk_reg_bank_pkg;

  localparam logic [1:0] MODE_JK     = 2'b00;
  localparam logic [1:0] MODE_LOAD   = 2'b01;
  localparam logic [1:0] MODE_TOGGLE = 2'b10;
  localparam logic [1:0] MODE_NOP    = 2'b11;

  localparam int unsigned MAX_WIDTH = 64;
  typedef logic [MAX_WIDTH-1:0] word_t;

  // JK per bit: set where j&~k, clear where ~j&k, toggle where j&k, hold otherwise.
  function automatic word_t jk_next(input word_t q, input word_t j, input word_t k,
                                    input logic [1:0] mode);
    word_t r;
    case (mode)
      MODE_JK:     r = (j & ~q) | (~k & q);
      MODE_LOAD:   r = j;
      MODE_TOGGLE: r = q ^ j;
      default:     r = q;
    endcase
    return r;
  endfunction

endpackage

// File: rtl/jk_reg_bank_word_next.sv
// jk_word_next: combinational next-word logic for one JK register word.
module jk_word_next
  import jk_reg_bank_pkg::*;
#(
  parameter int WIDTH = 8
) (
  input  logic [WIDTH-1:0] q,
  input  logic [WIDTH-1:0] j,
  input  logic [WIDTH-1:0] k,
  input  logic [1:0]       mode,
  output logic [WIDTH-1:0] q_next
);

  assign q_next = WIDTH'(jk_next(MAX_WIDTH'(q), MAX_WIDTH'(j), MAX_WIDTH'(k), mode));

endmodule

// File: rtl/jk_reg_bank.sv
// DEPTH x WIDTH bank of JK flip-flops with one masked write port and one registered read port.
// Define JK_REG_BANK_WR_BYPASS_EN to make a same-address read return the post-write value.
module jk_reg_bank
  import jk_reg_bank_pkg::*;
#(
  parameter int WIDTH = 8,
  parameter int DEPTH = 16,
  parameter int AW    = $clog2(DEPTH)
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             clr_all,
  input  logic             wr_en,
  input  logic [AW-1:0]    wr_addr,
  input  logic [1:0]       wr_mode,
  input  logic [WIDTH-1:0] j,
  input  logic [WIDTH-1:0] k,
  input  logic             rd_en,
  input  logic [AW-1:0]    rd_addr,
  output logic [WIDTH-1:0] rd_data,
  output logic             rd_valid,
  output logic             addr_err
);

  localparam int unsigned DEPTH_U = DEPTH;

  logic [WIDTH-1:0] mem [DEPTH];
  logic             wr_ok;
  logic             rd_ok;
  logic [WIDTH-1:0] wr_q;
  logic [WIDTH-1:0] wr_next;
  logic [WIDTH-1:0] rd_word;
  logic [WIDTH-1:0] rd_val;

  // Out-of-range addresses are masked here so no array access goes past DEPTH.
  always_comb begin
    wr_ok   = 32'(wr_addr) < DEPTH_U;
    rd_ok   = 32'(rd_addr) < DEPTH_U;
    wr_q    = wr_ok ? mem[wr_addr] : '0;
    rd_word = rd_ok ? mem[rd_addr] : '0;
  end

  jk_word_next #(.WIDTH(WIDTH)) u_wr_next (
    .q      (wr_q),
    .j      (j),
    .k      (k),
    .mode   (wr_mode),
    .q_next (wr_next)
  );

`ifdef JK_REG_BANK_WR_BYPASS_EN
  logic [WIDTH-1:0] byp_next;

  jk_word_next #(.WIDTH(WIDTH)) u_byp_next (
    .q      (rd_word),
    .j      (j),
    .k      (k),
    .mode   (wr_mode),
    .q_next (byp_next)
  );

  always_comb begin
    rd_val = rd_word;
    if (wr_en && wr_ok && rd_ok && (wr_addr == rd_addr))
      rd_val = clr_all ? '0 : byp_next;
  end
`else
  assign rd_val = rd_word;
`endif

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int unsigned i = 0; i < DEPTH_U; i++) mem[i] <= '0;
      rd_data  <= '0;
      rd_valid <= 1'b0;
      addr_err <= 1'b0;
    end else begin
      if (clr_all) begin
        for (int unsigned i = 0; i < DEPTH_U; i++) mem[i] <= '0;
      end else if (wr_en && wr_ok) begin
        mem[wr_addr] <= wr_next;
      end
      rd_valid <= rd_en;
      if (rd_en) rd_data <= rd_val;
      addr_err <= (wr_en && !wr_ok) || (rd_en && !rd_ok);
    end
  end

endmodule

// File: tb/tb_jk_reg_bank.sv
// Self-checking bench for jk_reg_bank (DEPTH=12 so out-of-range addresses exist).
// Honours JK_REG_BANK_WR_BYPASS_EN for the same-address read expectation.
module tb_jk_reg_bank;

  localparam int W = 8;
  localparam int D = 12;
  localparam int A = 4;

  localparam logic [1:0] M_JK  = 2'b00;
  localparam logic [1:0] M_LD  = 2'b01;
  localparam logic [1:0] M_TG  = 2'b10;
  localparam logic [1:0] M_NOP = 2'b11;

`ifdef JK_REG_BANK_WR_BYPASS_EN
  localparam bit BYP = 1'b1;
`else
  localparam bit BYP = 1'b0;
`endif

  logic         clk = 1'b0;
  logic         reset;
  logic         clr_all;
  logic         wr_en;
  logic [A-1:0] wr_addr;
  logic [1:0]   wr_mode;
  logic [W-1:0] j;
  logic [W-1:0] k;
  logic         rd_en;
  logic [A-1:0] rd_addr;
  logic [W-1:0] rd_data;
  logic         rd_valid;
  logic         addr_err;

  int n_cmp = 0;
  int n_err = 0;

  logic [W-1:0] m_mem [D];
  logic [W-1:0] e_data;
  logic         e_valid;
  logic         e_err;

  always #5 clk = ~clk;

  jk_reg_bank #(.WIDTH(W), .DEPTH(D)) dut (
    .clk      (clk),
    .reset    (reset),
    .clr_all  (clr_all),
    .wr_en    (wr_en),
    .wr_addr  (wr_addr),
    .wr_mode  (wr_mode),
    .j        (j),
    .k        (k),
    .rd_en    (rd_en),
    .rd_addr  (rd_addr),
    .rd_data  (rd_data),
    .rd_valid (rd_valid),
    .addr_err (addr_err)
  );

  // Reference: each bit decided independently from its (j,k) pair.
  function automatic logic [W-1:0] ref_next(input logic [W-1:0] q, input logic [W-1:0] jj,
                                            input logic [W-1:0] kk, input logic [1:0] md);
    logic [W-1:0] r;
    r = q;
    for (int b = 0; b < W; b++) begin
      case (md)
        M_JK: begin
          if (jj[b] && kk[b]) r[b] = !q[b];
          else if (jj[b])     r[b] = 1'b1;
          else if (kk[b])     r[b] = 1'b0;
        end
        M_LD:    r[b] = jj[b];
        M_TG:    r[b] = jj[b] ? !q[b] : q[b];
        default: r[b] = q[b];
      endcase
    end
    return r;
  endfunction

  task automatic model_clear();
    for (int i = 0; i < D; i++) m_mem[i] = '0;
    e_data  = '0;
    e_valid = 1'b0;
    e_err   = 1'b0;
  endtask

  task automatic drive(input logic we, input int wa, input logic [1:0] wm,
                       input logic [W-1:0] jj, input logic [W-1:0] kk,
                       input logic re, input int ra, input logic ca);
    wr_en   = we;
    wr_addr = A'(wa);
    wr_mode = wm;
    j       = jj;
    k       = kk;
    rd_en   = re;
    rd_addr = A'(ra);
    clr_all = ca;
  endtask

  task automatic idle();
    drive(1'b0, 0, M_JK, '0, '0, 1'b0, 0, 1'b0);
  endtask

  // Advance the model by one edge using the currently driven inputs, then clock the DUT.
  task automatic tick();
    bit w_in;
    bit r_in;
    w_in    = int'(wr_addr) < D;
    r_in    = int'(rd_addr) < D;
    e_err   = (wr_en && !w_in) || (rd_en && !r_in);
    e_valid = rd_en;
    if (rd_en) begin
      if (!r_in)
        e_data = '0;
      else if (BYP && wr_en && w_in && wr_addr == rd_addr)
        e_data = clr_all ? '0 : ref_next(m_mem[rd_addr], j, k, wr_mode);
      else
        e_data = m_mem[rd_addr];
    end
    if (clr_all) begin
      for (int i = 0; i < D; i++) m_mem[i] = '0;
    end else if (wr_en && w_in) begin
      m_mem[wr_addr] = ref_next(m_mem[wr_addr], j, k, wr_mode);
    end
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    idle();
    drive(1'b1, 2, M_LD, 8'h3C, '0, 1'b0, 0, 1'b0); tick();
    drive(1'b1, 13, M_LD, 8'hFF, '0, 1'b1, 2, 1'b0); tick();
    n_cmp++; if (rd_data !== 8'h3C) begin n_err++; $display("FAIL rst_pre_data got %h exp 3c", rd_data); end
    n_cmp++; if (addr_err !== 1'b1) begin n_err++; $display("FAIL rst_pre_err got %b exp 1", addr_err); end
    idle();
    #2 reset = 1'b1;
    model_clear();
    #1;
    n_cmp++; if (rd_data !== 8'h00) begin n_err++; $display("FAIL rst_async_data got %h exp 00", rd_data); end
    n_cmp++; if (addr_err !== 1'b0) begin n_err++; $display("FAIL rst_async_err got %b exp 0", addr_err); end
    n_cmp++; if (rd_valid !== 1'b0) begin n_err++; $display("FAIL rst_async_valid got %b exp 0", rd_valid); end
    drive(1'b0, 0, M_JK, '0, '0, 1'b1, 2, 1'b0);
    @(posedge clk); #1;
    n_cmp++; if (rd_valid !== 1'b0) begin n_err++; $display("FAIL rst_held_valid got %b exp 0", rd_valid); end
    @(negedge clk);
    reset = 1'b0;
    for (int a = 0; a < 16; a++) begin
      drive(1'b0, 0, M_JK, '0, '0, 1'b1, a, 1'b0); tick();
      n_cmp++; if (rd_data !== 8'h00) begin n_err++; $display("FAIL rst_read a=%0d got %h exp 00", a, rd_data); end
      n_cmp++; if (rd_valid !== 1'b1) begin n_err++; $display("FAIL rst_read_valid a=%0d got %b exp 1", a, rd_valid); end
      n_cmp++; if (addr_err !== (a >= D)) begin n_err++; $display("FAIL rst_read_err a=%0d got %b exp %b", a, addr_err, a >= D); end
    end
    idle();
  endtask

  task automatic test_jk_mode();
    drive(1'b1, 3, M_LD, 8'hF0, '0, 1'b0, 0, 1'b0); tick();
    drive(1'b1, 2, M_LD, 8'h12, '0, 1'b0, 0, 1'b0); tick();
    drive(1'b1, 4, M_LD, 8'h34, '0, 1'b0, 0, 1'b0); tick();
    drive(1'b1, 3, M_JK, 8'hCC, 8'hAA, 1'b0, 0, 1'b0); tick();
    drive(1'b0, 0, M_JK, '0, '0, 1'b1, 3, 1'b0); tick();
    // F0 with j=CC,k=AA: toggle/set/clear/hold on high nibble, toggle/set/clear/hold on low.
    n_cmp++; if (rd_data !== 8'h5C) begin n_err++; $display("FAIL jk_word3 got %h exp 5c", rd_data); end
    n_cmp++; if (rd_data !== e_data) begin n_err++; $display("FAIL jk_word3_model got %h exp %h", rd_data, e_data); end
    drive(1'b0, 0, M_JK, '0, '0, 1'b1, 2, 1'b0); tick();
    n_cmp++; if (rd_data !== 8'h12) begin n_err++; $display("FAIL jk_word2 got %h exp 12", rd_data); end
    drive(1'b0, 0, M_JK, '0, '0, 1'b1, 4, 1'b0); tick();
    n_cmp++; if (rd_data !== 8'h34) begin n_err++; $display("FAIL jk_word4 got %h exp 34", rd_data); end
    idle();
  endtask

  task automatic test_load_toggle();
    drive(1'b1, 7, M_LD, 8'h5A, '0, 1'b0, 0, 1'b0); tick();
    drive(1'b1, 7, M_TG, 8'hFF, 8'h0F, 1'b0, 0, 1'b0); tick();
    n_cmp++; if (rd_valid !== 1'b0) begin n_err++; $display("FAIL lt_valid_idle got %b exp 0", rd_valid); end
    drive(1'b0, 0, M_JK, '0, '0, 1'b1, 7, 1'b0); tick();
    n_cmp++; if (rd_valid !== 1'b1) begin n_err++; $display("FAIL lt_valid got %b exp 1", rd_valid); end
    n_cmp++; if (rd_data !== 8'hA5) begin n_err++; $display("FAIL lt_data got %h exp a5", rd_data); end
    idle(); tick();
    n_cmp++; if (rd_valid !== 1'b0) begin n_err++; $display("FAIL lt_pulse got %b exp 0", rd_valid); end
    n_cmp++; if (rd_data !== 8'hA5) begin n_err++; $display("FAIL lt_hold got %h exp a5", rd_data); end
    drive(1'b1, 7, M_NOP, 8'hFF, 8'hFF, 1'b1, 7, 1'b0); tick();
    n_cmp++; if (rd_data !== 8'hA5) begin n_err++; $display("FAIL nop_data got %h exp a5", rd_data); end
    n_cmp++; if (addr_err !== 1'b0) begin n_err++; $display("FAIL nop_err got %b exp 0", addr_err); end
    idle();
  endtask

  task automatic test_rw_collision();
    logic [W-1:0] exp_same;
    exp_same = BYP ? 8'h22 : 8'h11;
    drive(1'b1, 0, M_LD, 8'h11, '0, 1'b0, 0, 1'b0); tick();
    drive(1'b1, 0, M_LD, 8'h22, '0, 1'b1, 0, 1'b0); tick();
    n_cmp++; if (rd_data !== exp_same) begin n_err++; $display("FAIL coll_same got %h exp %h", rd_data, exp_same); end
    drive(1'b0, 0, M_JK, '0, '0, 1'b1, 0, 1'b0); tick();
    n_cmp++; if (rd_data !== 8'h22) begin n_err++; $display("FAIL coll_next got %h exp 22", rd_data); end
    idle();
  endtask

  task automatic test_clr_all();
    drive(1'b1, 5, M_LD, 8'h99, '0, 1'b0, 0, 1'b0); tick();
    drive(1'b1, 1, M_LD, 8'hFF, '0, 1'b1, 5, 1'b1); tick();
    n_cmp++; if (rd_data !== 8'h99) begin n_err++; $display("FAIL clr_preread got %h exp 99", rd_data); end
    for (int a = 0; a < D; a++) begin
      drive(1'b0, 0, M_JK, '0, '0, 1'b1, a, 1'b0); tick();
      n_cmp++; if (rd_data !== 8'h00) begin n_err++; $display("FAIL clr_word a=%0d got %h exp 00", a, rd_data); end
    end
    idle();
  endtask

  task automatic test_out_of_range();
    drive(1'b1, 6, M_LD, 8'h6E, '0, 1'b0, 0, 1'b0); tick();
    drive(1'b1, 13, M_LD, 8'hFF, '0, 1'b0, 0, 1'b0); tick();
    n_cmp++; if (addr_err !== 1'b1) begin n_err++; $display("FAIL oor_wr_err got %b exp 1", addr_err); end
    n_cmp++; if (rd_valid !== 1'b0) begin n_err++; $display("FAIL oor_wr_valid got %b exp 0", rd_valid); end
    idle(); tick();
    n_cmp++; if (addr_err !== 1'b0) begin n_err++; $display("FAIL oor_err_pulse got %b exp 0", addr_err); end
    drive(1'b0, 0, M_JK, '0, '0, 1'b1, 13, 1'b0); tick();
    n_cmp++; if (rd_data !== 8'h00) begin n_err++; $display("FAIL oor_rd_data got %h exp 00", rd_data); end
    n_cmp++; if (rd_valid !== 1'b1) begin n_err++; $display("FAIL oor_rd_valid got %b exp 1", rd_valid); end
    n_cmp++; if (addr_err !== 1'b1) begin n_err++; $display("FAIL oor_rd_err got %b exp 1", addr_err); end
    for (int a = 0; a < D; a++) begin
      drive(1'b0, 0, M_JK, '0, '0, 1'b1, a, 1'b0); tick();
      n_cmp++; if (rd_data !== e_data) begin n_err++; $display("FAIL oor_unchanged a=%0d got %h exp %h", a, rd_data, e_data); end
    end
    idle();
  endtask

  task automatic test_random();
    int wa;
    for (int c = 0; c < 400; c++) begin
      wa = int'($urandom_range(0, 15));
      drive(1'b1 & $urandom_range(0, 1), wa, 2'($urandom_range(0, 3)),
            8'($urandom), 8'($urandom), 1'b1 & $urandom_range(0, 1),
            ($urandom_range(0, 3) == 0) ? wa : int'($urandom_range(0, 15)),
            $urandom_range(0, 24) == 0);
      tick();
      n_cmp++; if (rd_valid !== e_valid) begin n_err++; $display("FAIL rnd_valid c=%0d got %b exp %b", c, rd_valid, e_valid); end
      n_cmp++; if (rd_data !== e_data) begin n_err++; $display("FAIL rnd_data c=%0d got %h exp %h", c, rd_data, e_data); end
      n_cmp++; if (addr_err !== e_err) begin n_err++; $display("FAIL rnd_err c=%0d got %b exp %b", c, addr_err, e_err); end
    end
    for (int a = 0; a < D; a++) begin
      drive(1'b0, 0, M_JK, '0, '0, 1'b1, a, 1'b0); tick();
      n_cmp++; if (rd_data !== e_data) begin n_err++; $display("FAIL rnd_final a=%0d got %h exp %h", a, rd_data, e_data); end
    end
    idle();
  endtask

  initial begin
    reset = 1'b1;
    idle();
    model_clear();
    #12 reset = 1'b0;
    test_reset();
    test_jk_mode();
    test_load_toggle();
    test_rw_collision();
    test_clr_all();
    test_out_of_range();
    test_random();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
